// File: rtl/rx_dispatch_module_pkg.sv
// Shared receive/transmit layer constants and dispatch types.
// Used by the rx dispatcher and the tx arbiter.
package rx_dispatch_module_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    localparam int MAC_USER_W   = 80;
    localparam int MAC_TYPE_LSB = 0;
    localparam int MAC_TYPE_W   = 16;

    localparam int IP_USER_W   = 56;
    localparam int IP_TYPE_LSB = 29;
    localparam int IP_TYPE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD_C0,
        ST_FWD_C1,
        ST_DROP
    } disp_state_t;

    typedef enum logic [1:0] {
        ROUTE_C0,
        ROUTE_C1,
        ROUTE_DROP
    } route_t;

    // Channel 0 takes priority when both type values are equal.
    function automatic route_t classify(
        input logic [15:0] t,
        input logic [15:0] c0,
        input logic [15:0] c1
    );
        if (t == c0)
            return ROUTE_C0;
        else if (t == c1)
            return ROUTE_C1;
        else
            return ROUTE_DROP;
    endfunction

endpackage

// File: rtl/rx_dispatch_module_if.sv
// AXI-Stream bundle with 64-bit data and parameterised tuser.
// master drives the beat, slave drives ready.
interface rx_dispatch_module_if
    import rx_dispatch_module_pkg::*;
#(
    parameter int USER_W = 80
) ();

    logic [AXIS_DATA_W-1:0] data;
    logic [USER_W-1:0]      user;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic                   valid;
    logic                   ready;

    modport master (
        output data,
        output user,
        output keep,
        output last,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  user,
        input  keep,
        input  last,
        input  valid,
        output ready
    );

endinterface

// File: rtl/rx_dispatch_module_axis_reg_slice.sv
// One-entry output register stage shared by both channels.
// Carries a channel tag so the top can steer valid and ready.
module rx_dispatch_module_axis_reg_slice
    import rx_dispatch_module_pkg::*;
#(
    parameter int USER_W = 80
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AXIS_DATA_W-1:0] in_data,
    input  logic [USER_W-1:0]      in_user,
    input  logic [AXIS_KEEP_W-1:0] in_keep,
    input  logic                   in_last,
    input  logic                   in_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AXIS_DATA_W-1:0] out_data,
    output logic [USER_W-1:0]      out_user,
    output logic [AXIS_KEEP_W-1:0] out_keep,
    output logic                   out_last,
    output logic                   out_ch
);

    // Full stage with downstream ready swaps in a new beat the same cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_ch    <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_user <= in_user;
                out_keep <= in_keep;
                out_last <= in_last;
                out_ch   <= in_ch;
            end
        end
    end

endmodule

// File: rtl/rx_dispatch_module.sv
// Routes whole packets from one AXI-Stream to one of two consumers
// by a tuser type field; unknown types are dropped and counted.
module rx_dispatch_module
    import rx_dispatch_module_pkg::*;
#(
    parameter int          P_USER_W   = 80,
    parameter int          P_TYPE_LSB = 0,
    parameter int          P_TYPE_W   = 16,
    parameter logic [15:0] P_C0_TYPE  = ETH_TYPE_IP,
    parameter logic [15:0] P_C1_TYPE  = ETH_TYPE_ARP
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rx_dispatch_module_if.slave   s_axis_in,
    rx_dispatch_module_if.master  m_axis_c0,
    rx_dispatch_module_if.master  m_axis_c1,
    output logic [15:0]           o_c0_pkt_cnt,
    output logic [15:0]           o_c1_pkt_cnt,
    output logic [15:0]           o_drop_cnt
);

    disp_state_t state_q;
    disp_state_t state_d;
    route_t      route;

    logic [P_TYPE_W-1:0] type_f;
    logic [P_USER_W-1:0] user_q;
    logic [P_USER_W-1:0] in_user;

    logic fwd;
    logic fwd_ch;
    logic drop_hit;
    logic s_ready;
    logic accept;
    logic slice_in_ready;

    logic                   out_valid;
    logic                   out_ready;
    logic [AXIS_DATA_W-1:0] out_data;
    logic [P_USER_W-1:0]    out_user;
    logic [AXIS_KEEP_W-1:0] out_keep;
    logic                   out_last;
    logic                   out_ch;

    logic c0_done;
    logic c1_done;

    assign type_f = s_axis_in.user[P_TYPE_LSB +: P_TYPE_W];
    assign route  = classify(16'(type_f), P_C0_TYPE, P_C1_TYPE);

    // Drop mode sinks beats regardless of the output stage.
    assign s_ready = !i_rst &&
                     ((state_q == ST_DROP) || slice_in_ready);
    assign s_axis_in.ready = s_ready;
    assign accept = s_axis_in.valid && s_ready;

    assign in_user = (state_q == ST_IDLE) ? s_axis_in.user : user_q;

    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        fwd_ch   = 1'b0;
        drop_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                fwd    = (route != ROUTE_DROP);
                fwd_ch = (route == ROUTE_C1);
                if (accept) begin
                    drop_hit = s_axis_in.last && !fwd;
                    if (!s_axis_in.last) begin
                        unique case (route)
                            ROUTE_C0: state_d = ST_FWD_C0;
                            ROUTE_C1: state_d = ST_FWD_C1;
                            default:  state_d = ST_DROP;
                        endcase
                    end
                end
            end
            ST_FWD_C0: begin
                fwd = 1'b1;
                if (accept && s_axis_in.last)
                    state_d = ST_IDLE;
            end
            ST_FWD_C1: begin
                fwd    = 1'b1;
                fwd_ch = 1'b1;
                if (accept && s_axis_in.last)
                    state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (accept && s_axis_in.last) begin
                    state_d  = ST_IDLE;
                    drop_hit = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // First-beat tuser is held for the rest of the packet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            user_q <= '0;
        else if (accept && state_q == ST_IDLE)
            user_q <= s_axis_in.user;
    end

    assign out_ready = out_ch ? m_axis_c1.ready : m_axis_c0.ready;

    rx_dispatch_module_axis_reg_slice #(
        .USER_W (P_USER_W)
    ) u_slice (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .in_valid  (s_axis_in.valid && fwd),
        .in_ready  (slice_in_ready),
        .in_data   (s_axis_in.data),
        .in_user   (in_user),
        .in_keep   (s_axis_in.keep),
        .in_last   (s_axis_in.last),
        .in_ch     (fwd_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_user  (out_user),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_ch    (out_ch)
    );

    assign m_axis_c0.valid = out_valid && !out_ch;
    assign m_axis_c0.data  = out_data;
    assign m_axis_c0.user  = out_user;
    assign m_axis_c0.keep  = out_keep;
    assign m_axis_c0.last  = out_last;

    assign m_axis_c1.valid = out_valid && out_ch;
    assign m_axis_c1.data  = out_data;
    assign m_axis_c1.user  = out_user;
    assign m_axis_c1.keep  = out_keep;
    assign m_axis_c1.last  = out_last;

    assign c0_done = out_valid && !out_ch &&
                     m_axis_c0.ready && out_last;
    assign c1_done = out_valid && out_ch &&
                     m_axis_c1.ready && out_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_c0_pkt_cnt <= '0;
            o_c1_pkt_cnt <= '0;
            o_drop_cnt   <= '0;
        end else begin
            if (c0_done)
                o_c0_pkt_cnt <= o_c0_pkt_cnt + 16'd1;
            if (c1_done)
                o_c1_pkt_cnt <= o_c1_pkt_cnt + 16'd1;
            if (drop_hit)
                o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rx_dispatch_module.sv
// Directed bench for rx_dispatch_module in MAC and IP configurations.
// Expected values are hand-computed per scenario.
module tb_rx_dispatch_module;
    import rx_dispatch_module_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_dispatch_module_if #(.USER_W(80)) min ();
    rx_dispatch_module_if #(.USER_W(80)) mc0 ();
    rx_dispatch_module_if #(.USER_W(80)) mc1 ();
    rx_dispatch_module_if #(.USER_W(56)) pin ();
    rx_dispatch_module_if #(.USER_W(56)) pc0 ();
    rx_dispatch_module_if #(.USER_W(56)) pc1 ();

    logic [15:0] m_c0_cnt, m_c1_cnt, m_drop;
    logic [15:0] p_c0_cnt, p_c1_cnt, p_drop;

    rx_dispatch_module #(
        .P_USER_W(80), .P_TYPE_LSB(0), .P_TYPE_W(16),
        .P_C0_TYPE(ETH_TYPE_IP), .P_C1_TYPE(ETH_TYPE_ARP)
    ) u_mac (
        .i_clk(clk), .i_rst(rst),
        .s_axis_in(min), .m_axis_c0(mc0), .m_axis_c1(mc1),
        .o_c0_pkt_cnt(m_c0_cnt), .o_c1_pkt_cnt(m_c1_cnt),
        .o_drop_cnt(m_drop)
    );

    rx_dispatch_module #(
        .P_USER_W(56), .P_TYPE_LSB(29), .P_TYPE_W(8),
        .P_C0_TYPE(16'(IP_PROTO_ICMP)), .P_C1_TYPE(16'(IP_PROTO_UDP))
    ) u_ip (
        .i_clk(clk), .i_rst(rst),
        .s_axis_in(pin), .m_axis_c0(pc0), .m_axis_c1(pc1),
        .o_c0_pkt_cnt(p_c0_cnt), .o_c1_pkt_cnt(p_c1_cnt),
        .o_drop_cnt(p_drop)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [79:0] u;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_c0 = 0, exp_c1 = 0, exp_drop = 0;
    logic tog_en = 1'b0;

    beat_t q0[$], q1[$];
    logic [63:0] ipq0[$], ipq1[$];
    int in_cyc[$], o0_cyc[$];
    int cyc = 0, vseen = 0, vseen1 = 0, viol = 0;
    beat_t cur0, prev0;
    logic prev_stall0 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        cur0 = '{d: mc0.data, u: mc0.user, k: mc0.keep, l: mc0.last};
        if (min.valid && min.ready) in_cyc.push_back(cyc);
        if (mc0.valid && mc0.ready) begin
            q0.push_back(cur0);
            o0_cyc.push_back(cyc);
        end
        if (mc1.valid && mc1.ready)
            q1.push_back('{d: mc1.data, u: mc1.user, k: mc1.keep, l: mc1.last});
        if (mc0.valid || mc1.valid) vseen++;
        if (mc1.valid) vseen1++;
        if (prev_stall0 && (!mc0.valid || cur0 !== prev0)) viol++;
        prev_stall0 = mc0.valid && !mc0.ready && !rst;
        prev0 = cur0;
        if (pc0.valid && pc0.ready) ipq0.push_back(pc0.data);
        if (pc1.valid && pc1.ready) ipq1.push_back(pc1.data);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog_en) mc0.ready = ~mc0.ready;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [79:0] u,
                              input logic [7:0] k, input logic l,
                              output int waits);
        logic acc;
        min.data = d; min.user = u; min.keep = k; min.last = l;
        min.valid = 1'b1;
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = min.ready;
            step();
            if (acc) begin
                min.valid = 1'b0;
                return;
            end
            waits++;
        end
        checks++; errors++;
        $display("FAIL mac_drive_timeout: beat %h not accepted, need ready", d);
        min.valid = 1'b0;
    endtask

    task automatic ip_beat(input logic [63:0] d, input logic [55:0] u,
                           input logic l);
        logic acc;
        pin.data = d; pin.user = u; pin.keep = 8'hFF; pin.last = l;
        pin.valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = pin.ready;
            step();
            if (acc) begin
                pin.valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ip_drive_timeout: beat %h not accepted, need ready", d);
        pin.valid = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        @(negedge clk);
        checks++; if (min.ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", min.ready); end
        checks++; if (mc0.valid !== 1'b0) begin errors++; $display("FAIL rst_c0_valid: got %b want 0", mc0.valid); end
        checks++; if (mc1.valid !== 1'b0) begin errors++; $display("FAIL rst_c1_valid: got %b want 0", mc1.valid); end
        checks++; if (m_c0_cnt !== 16'd0) begin errors++; $display("FAIL rst_c0_cnt: got %h want 0", m_c0_cnt); end
        checks++; if (m_drop !== 16'd0) begin errors++; $display("FAIL rst_drop: got %h want 0", m_drop); end
        checks++; if (mc0.data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h want 0", mc0.data); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (min.ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready: got %b want 1", min.ready); end
        checks++; if (pin.ready !== 1'b1) begin errors++; $display("FAIL rel_ip_ready: got %b want 1", pin.ready); end
        step();
    endtask

    task automatic test_single_pkt();
        int b0 = q0.size(), b1 = q1.size(), bi = in_cyc.size(), v1 = vseen1, w;
        logic [79:0] u = {64'h1111_2222_3333_4444, ETH_TYPE_IP};
        mc0.ready = 1'b1; mc1.ready = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_beat(64'hA000 + 64'(i), u, 8'hFF, i == 3, w);
        idle(3);
        exp_c0 = exp_c0 + 16'd1;
        checks++; if (q0.size() - b0 != 4) begin errors++; $display("FAIL t1_c0_beats: got %0d want 4", q0.size() - b0); end
        for (int i = 0; i < 4 && b0 + i < q0.size(); i++) begin
            checks++;
            if (q0[b0+i] !== beat_t'{64'hA000 + 64'(i), u, 8'hFF, i == 3}) begin
                errors++; $display("FAIL t1_beat%0d: got %h want d=%h l=%0d", i, q0[b0+i], 64'hA000 + 64'(i), i == 3);
            end
        end
        checks++; if (q1.size() != b1 || vseen1 != v1) begin errors++; $display("FAIL t1_c1_quiet: got %0d valids want 0", vseen1 - v1); end
        checks++; if (m_c0_cnt !== exp_c0) begin errors++; $display("FAIL t1_c0_cnt: got %h want %h", m_c0_cnt, exp_c0); end
        if (q0.size() - b0 == 4) begin
            checks++;
            if (o0_cyc[o0_cyc.size()-4] - in_cyc[bi] != 1) begin
                errors++; $display("FAIL t1_latency: got %0d want 1", o0_cyc[o0_cyc.size()-4] - in_cyc[bi]);
            end
            checks++;
            if (o0_cyc[o0_cyc.size()-1] - o0_cyc[o0_cyc.size()-4] != 3) begin
                errors++; $display("FAIL t1_throughput: got span %0d want 3", o0_cyc[o0_cyc.size()-1] - o0_cyc[o0_cyc.size()-4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b0 = q0.size(), b1 = q1.size(), w, wt = 0;
        logic [79:0] ua = {64'h0, ETH_TYPE_ARP};
        logic [79:0] ui = {64'h5, ETH_TYPE_IP};
        drive_beat(64'hB000, ua, 8'hFF, 1'b0, w); wt += w;
        drive_beat(64'hB001, ua, 8'h3F, 1'b1, w); wt += w;
        drive_beat(64'hC000, ui, 8'h01, 1'b1, w); wt += w;
        idle(3);
        exp_c0 = exp_c0 + 16'd1; exp_c1 = exp_c1 + 16'd1;
        checks++; if (q1.size() - b1 != 2) begin errors++; $display("FAIL t2_c1_beats: got %0d want 2", q1.size() - b1); end
        if (q1.size() - b1 == 2) begin
            checks++; if (q1[b1] !== beat_t'{64'hB000, ua, 8'hFF, 1'b0}) begin errors++; $display("FAIL t2_c1_b0: got %h", q1[b1]); end
            checks++; if (q1[b1+1] !== beat_t'{64'hB001, ua, 8'h3F, 1'b1}) begin errors++; $display("FAIL t2_c1_b1: got %h", q1[b1+1]); end
        end
        checks++; if (q0.size() - b0 != 1) begin errors++; $display("FAIL t2_c0_beats: got %0d want 1", q0.size() - b0); end
        if (q0.size() - b0 == 1) begin
            checks++; if (q0[b0] !== beat_t'{64'hC000, ui, 8'h01, 1'b1}) begin errors++; $display("FAIL t2_c0_b0: got %h", q0[b0]); end
        end
        checks++; if (wt != 0) begin errors++; $display("FAIL t2_no_bubble: got %0d waits want 0", wt); end
        checks++; if (m_c1_cnt !== exp_c1) begin errors++; $display("FAIL t2_c1_cnt: got %h want %h", m_c1_cnt, exp_c1); end
        checks++; if (m_c0_cnt !== exp_c0) begin errors++; $display("FAIL t2_c0_cnt: got %h want %h", m_c0_cnt, exp_c0); end
    endtask

    task automatic test_drop();
        int b0 = q0.size(), b1 = q1.size(), vs, w, wt = 0;
        logic [79:0] u = {64'h9, 16'h86DD};
        mc0.ready = 1'b0; mc1.ready = 1'b0;
        vs = vseen;
        for (int i = 0; i < 3; i++) begin
            drive_beat(64'hD000 + 64'(i), u, 8'hFF, i == 2, w);
            wt += w;
        end
        idle(2);
        exp_drop = exp_drop + 16'd1;
        checks++; if (wt != 0) begin errors++; $display("FAIL t3_s_ready: got %0d waits want 0", wt); end
        checks++; if (vseen != vs) begin errors++; $display("FAIL t3_no_valid: got %0d valids want 0", vseen - vs); end
        checks++; if (q0.size() != b0 || q1.size() != b1) begin errors++; $display("FAIL t3_no_beats: got extra beats"); end
        checks++; if (m_drop !== exp_drop) begin errors++; $display("FAIL t3_drop_cnt: got %h want %h", m_drop, exp_drop); end
    endtask

    task automatic test_stall();
        logic [7:0] kt [6] = '{8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h01, 8'h80};
        logic [79:0] ua = {64'hFEED, ETH_TYPE_IP};
        logic [79:0] ub = {64'hBAD0, ETH_TYPE_ARP};
        int b0 = q0.size(), b1 = q1.size(), vi = viol, w;
        mc0.ready = 1'b1; mc1.ready = 1'b1;
        tog_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_beat(64'hE000 + 64'(i), (i == 0) ? ua : ub, kt[i], i == 5, w);
            if (i == 2) begin
                idle(2);
                @(negedge clk);
                checks++; if (mc0.valid !== 1'b0) begin errors++; $display("FAIL t4_gap_drain: got valid %b want 0", mc0.valid); end
                step();
            end
        end
        idle(6);
        tog_en = 1'b0; mc0.ready = 1'b1;
        idle(2);
        exp_c0 = exp_c0 + 16'd1;
        checks++; if (viol != vi) begin errors++; $display("FAIL t4_stable: got %0d changes while stalled want 0", viol - vi); end
        checks++; if (q0.size() - b0 != 6) begin errors++; $display("FAIL t4_beats: got %0d want 6", q0.size() - b0); end
        for (int i = 0; i < 6 && b0 + i < q0.size(); i++) begin
            checks++;
            if (q0[b0+i] !== beat_t'{64'hE000 + 64'(i), ua, kt[i], i == 5}) begin
                errors++; $display("FAIL t4_beat%0d: got %h want d=%h k=%h", i, q0[b0+i], 64'hE000 + 64'(i), kt[i]);
            end
        end
        checks++; if (q1.size() != b1) begin errors++; $display("FAIL t4_c1_quiet: got %0d beats want 0", q1.size() - b1); end
        checks++; if (m_c0_cnt !== exp_c0) begin errors++; $display("FAIL t4_c0_cnt: got %h want %h", m_c0_cnt, exp_c0); end
    endtask

    task automatic test_reset_mid();
        int b0 = q0.size(), b1 = q1.size(), w;
        logic [79:0] ui = {64'h77, ETH_TYPE_IP};
        logic [79:0] ua = {64'h88, ETH_TYPE_ARP};
        mc0.ready = 1'b1; mc1.ready = 1'b1;
        drive_beat(64'hF000, ui, 8'hFF, 1'b0, w);
        drive_beat(64'hF001, ui, 8'hFF, 1'b0, w);
        min.data = 64'hF002; min.user = ui; min.last = 1'b0;
        min.valid = 1'b1;
        rst = 1'b1;
        #1;
        exp_c0 = 0; exp_c1 = 0; exp_drop = 0;
        checks++; if (min.ready !== 1'b0) begin errors++; $display("FAIL t5_s_ready: got %b want 0", min.ready); end
        checks++; if (mc0.valid !== 1'b0 || mc1.valid !== 1'b0) begin errors++; $display("FAIL t5_valids: got %b%b want 00", mc0.valid, mc1.valid); end
        checks++; if ({m_c0_cnt, m_c1_cnt, m_drop} !== 48'd0) begin errors++; $display("FAIL t5_cnts: got %h %h %h want 0", m_c0_cnt, m_c1_cnt, m_drop); end
        checks++; if (mc0.data !== 64'd0 || mc0.user !== 80'd0) begin errors++; $display("FAIL t5_data: got %h want 0", mc0.data); end
        min.valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        drive_beat(64'h1E00, ua, 8'hFF, 1'b1, w);
        idle(3);
        exp_c1 = 16'd1;
        checks++; if (q0.size() - b0 != 1) begin errors++; $display("FAIL t5_c0_beats: got %0d want 1", q0.size() - b0); end
        checks++; if (q1.size() - b1 != 1) begin errors++; $display("FAIL t5_c1_beats: got %0d want 1", q1.size() - b1); end
        if (q1.size() - b1 == 1) begin
            checks++; if (q1[b1].d !== 64'h1E00) begin errors++; $display("FAIL t5_c1_data: got %h want 1e00", q1[b1].d); end
        end
        checks++; if (m_c1_cnt !== exp_c1 || m_c0_cnt !== exp_c0) begin errors++; $display("FAIL t5_cnts_after: got %h %h want 0 1", m_c0_cnt, m_c1_cnt); end
    endtask

    task automatic test_ip_cfg();
        logic [55:0] u17 = '0, u1 = '0, u6 = '0;
        int b0 = ipq0.size(), b1 = ipq1.size();
        u17[28:0] = 29'h123; u17[36:29] = IP_PROTO_UDP;
        u1[36:29] = IP_PROTO_ICMP; u1[55:37] = 19'h7FFFF;
        u6[36:29] = 8'd6;
        pc0.ready = 1'b1; pc1.ready = 1'b1;
        ip_beat(64'h1700, u17, 1'b0);
        ip_beat(64'h1701, u17, 1'b1);
        ip_beat(64'h0100, u1, 1'b1);
        idle(3);
        checks++; if (ipq1.size() - b1 != 2) begin errors++; $display("FAIL t6_c1_beats: got %0d want 2", ipq1.size() - b1); end
        if (ipq1.size() - b1 == 2) begin
            checks++; if (ipq1[b1] !== 64'h1700 || ipq1[b1+1] !== 64'h1701) begin errors++; $display("FAIL t6_c1_data: got %h %h", ipq1[b1], ipq1[b1+1]); end
        end
        checks++; if (ipq0.size() - b0 != 1) begin errors++; $display("FAIL t6_c0_beats: got %0d want 1", ipq0.size() - b0); end
        if (ipq0.size() - b0 == 1) begin
            checks++; if (ipq0[b0] !== 64'h0100) begin errors++; $display("FAIL t6_c0_data: got %h want 0100", ipq0[b0]); end
        end
        checks++; if (p_c1_cnt !== 16'd1 || p_c0_cnt !== 16'd1) begin errors++; $display("FAIL t6_cnts: got c0=%h c1=%h want 1 1", p_c0_cnt, p_c1_cnt); end
        for (int i = 0; i < 65535; i++)
            ip_beat(64'(i), u6, 1'b1);
        idle(2);
        checks++; if (p_drop !== 16'hFFFF) begin errors++; $display("FAIL t6_drop_max: got %h want ffff", p_drop); end
        ip_beat(64'h0, u6, 1'b1);
        idle(2);
        checks++; if (p_drop !== 16'h0000) begin errors++; $display("FAIL t6_drop_wrap: got %h want 0000", p_drop); end
        checks++; if (ipq0.size() - b0 != 1 || ipq1.size() - b1 != 2) begin errors++; $display("FAIL t6_drop_leak: got %0d %0d beats", ipq0.size() - b0, ipq1.size() - b1); end
    endtask

    initial begin
        min.valid = 1'b0; min.data = '0; min.user = '0;
        min.keep = '0; min.last = 1'b0;
        pin.valid = 1'b0; pin.data = '0; pin.user = '0;
        pin.keep = '0; pin.last = 1'b0;
        mc0.ready = 1'b0; mc1.ready = 1'b0;
        pc0.ready = 1'b0; pc1.ready = 1'b0;
        test_reset();
        test_single_pkt();
        test_back_to_back();
        test_drop();
        test_stall();
        test_reset_mid();
        test_ip_cfg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
